// File: rtl/receiver_word_fifo.sv
// ---------------------------------------------------------------------------
// receiver_word_fifo
//
// Assembles a stream of received bytes into WORD_BYTES-wide words and queues
// the completed words in a DEPTH-entry FIFO for a downstream consumer.
//
// The byte side has no back-pressure: a byte is taken on every rising edge
// with valid=1 and flush=0. When a word completes while the FIFO is full and
// nothing is popped on that edge, the word is dropped and the sticky
// overflow flag is raised.
//
// Parameters
//   WORD_BYTES  bytes per assembled word (2..8)
//   DEPTH       FIFO depth in words (power of two, 2..64)
//   BIG_ENDIAN  1: first byte lands in the MSBs, 0: first byte in the LSBs
//
// Ports
//   CLK        in   single clock, all state changes on its rising edge
//   reset      in   asynchronous active-low reset
//   data       in   received byte
//   valid      in   data holds a new byte this cycle
//   flush      in   discard the partially assembled word
//   clear_ovf  in   clear the sticky overflow flag
//   out_data   out  FIFO head word (zero while the FIFO is empty)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer pops the head when out_valid is high
//   count      out  words currently held (0..DEPTH)
//   partial    out  bytes of the current word accepted so far
//   overflow   out  sticky flag, set when a completed word was dropped
// ---------------------------------------------------------------------------
module receiver_word_fifo #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [7:0]                    data,
  input  logic                          valid,
  input  logic                          flush,
  input  logic                          clear_ovf,
  output logic [8*WORD_BYTES-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(WORD_BYTES):0]   partial,
  output logic                          overflow
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PART_W = $clog2(WORD_BYTES) + 1;

  localparam logic [PART_W-1:0] LAST_IDX = PART_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0] asm_q;               // bytes of the word being assembled
  logic [WORD_W-1:0] mem [DEPTH];         // word storage
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // -------------------------------------------------------------------------
  // Byte-side control
  // -------------------------------------------------------------------------
  logic byte_accept;   // a byte is taken this edge
  logic word_done;     // the byte taken this edge completes a word
  logic full;
  logic pop;
  logic push;
  logic ovf_event;     // a completed word is dropped this edge

  assign byte_accept = valid && !flush;
  assign word_done   = byte_accept && (partial == LAST_IDX);
  assign full        = (count == FULL_CNT);
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;

  // A pop on the same edge frees the slot the new word goes into, so a
  // completing word is only lost when the FIFO is full and nothing leaves.
  assign push        = word_done && (!full || pop);
  assign ovf_event   = word_done && full && !pop;

  // -------------------------------------------------------------------------
  // Word assembly: asm_q with the incoming byte dropped into lane `partial`.
  // Every lane is rewritten before a word completes, so bytes left over from
  // an abandoned word never reach the FIFO.
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0] word_next;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value held and no latch is inferred.
    word_next = asm_q;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (partial == PART_W'(k)) begin
        if (BIG_ENDIAN != 0) begin
          word_next[8*(WORD_BYTES-k)-1 -: 8] = data;
        end else begin
          word_next[8*k+7 -: 8] = data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control state: assembly counter, pointers, occupancy, overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) begin
      partial  <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Assembly counter: flush wins over valid; the last byte of a word
      // always returns it to 0, whether the word is queued or dropped.
      if (flush) begin
        partial <= '0;
      end else if (valid) begin
        partial <= word_done ? '0 : partial + PART_W'(1);
      end

      if (byte_accept) begin
        asm_q <= word_next;
      end

      // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A fresh drop on the same edge as clear_ovf leaves the flag set.
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word storage. When full with a simultaneous pop, wr_ptr equals rd_ptr:
  // the head is read out on this edge and its slot becomes the new tail.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: the storage array has no reset; an entry is only visible after
    // it has been written, and out_data is gated to zero while empty.
    if (push) begin
      mem[wr_ptr] <= word_next;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_receiver_word_fifo.sv
// ---------------------------------------------------------------------------
// tb_receiver_word_fifo
//
// Drives a big-endian and a little-endian instance of receiver_word_fifo
// from the same stimulus and compares both against a queue-based reference
// model of the byte-to-word receiver after every clock edge.
// ---------------------------------------------------------------------------
module tb_receiver_word_fifo;

  localparam int WB    = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        flush;
  logic        clear_ovf;
  logic        out_ready;

  logic [31:0] be_out_data;
  logic        be_out_valid;
  logic [2:0]  be_count;
  logic [2:0]  be_partial;
  logic        be_overflow;

  logic [31:0] le_out_data;
  logic        le_out_valid;
  logic [2:0]  le_count;
  logic [2:0]  le_partial;
  logic        le_overflow;

  receiver_word_fifo #(.WORD_BYTES(WB), .DEPTH(DEPTH), .BIG_ENDIAN(1)) u_be (
    .CLK       (clk),
    .reset     (rst_n),
    .data      (data),
    .valid     (valid),
    .flush     (flush),
    .clear_ovf (clear_ovf),
    .out_data  (be_out_data),
    .out_valid (be_out_valid),
    .out_ready (out_ready),
    .count     (be_count),
    .partial   (be_partial),
    .overflow  (be_overflow)
  );

  receiver_word_fifo #(.WORD_BYTES(WB), .DEPTH(DEPTH), .BIG_ENDIAN(0)) u_le (
    .CLK       (clk),
    .reset     (rst_n),
    .data      (data),
    .valid     (valid),
    .flush     (flush),
    .clear_ovf (clear_ovf),
    .out_data  (le_out_data),
    .out_valid (le_out_valid),
    .out_ready (out_ready),
    .count     (le_count),
    .partial   (le_partial),
    .overflow  (le_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes of the word in progress, the queued words in both
  // byte orders, and the sticky overflow flag.
  logic [7:0]  m_cur [$];
  logic [31:0] m_qbe [$];
  logic [31:0] m_qle [$];
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_qbe.delete();
    m_qle.delete();
    m_ovf = 1'b0;
  endtask

  // One clock edge of the receiver, from the pre-edge model state and inputs.
  task automatic model_step(input bit v, input logic [7:0] d, input bit f,
                            input bit c, input bit r);
    bit          do_pop;
    bit          evt;
    logic [31:0] wbe;
    logic [31:0] wle;
    do_pop = (m_qbe.size() > 0) && r;
    evt    = 1'b0;
    if (do_pop) begin
      void'(m_qbe.pop_front());
      void'(m_qle.pop_front());
    end
    if (f) begin
      m_cur.delete();
    end else if (v) begin
      m_cur.push_back(d);
      if (m_cur.size() == WB) begin
        wbe = '0;
        wle = '0;
        for (int i = 0; i < WB; i++) begin
          wbe = (wbe << 8) | 32'(m_cur[i]);
          wle = wle | (32'(m_cur[i]) << (8 * i));
        end
        m_cur.delete();
        if (m_qbe.size() < DEPTH) begin
          m_qbe.push_back(wbe);
          m_qle.push_back(wle);
        end else begin
          evt = 1'b1;
        end
      end
    end
    if (evt) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_be;
    logic [31:0] exp_le;
    exp_be = (m_qbe.size() > 0) ? m_qbe[0] : 32'h0;
    exp_le = (m_qle.size() > 0) ? m_qle[0] : 32'h0;
    check({tag, "_be_data"},  64'(be_out_data),  64'(exp_be));
    check({tag, "_le_data"},  64'(le_out_data),  64'(exp_le));
    check({tag, "_valid"},    64'(be_out_valid), 64'(m_qbe.size() > 0));
    check({tag, "_count"},    64'(be_count),     64'(m_qbe.size()));
    check({tag, "_partial"},  64'(be_partial),   64'(m_cur.size()));
    check({tag, "_overflow"}, 64'(be_overflow),  64'(m_ovf));
    check({tag, "_le_count"}, 64'(le_count),     64'(m_qle.size()));
    check({tag, "_le_ovf"},   64'(le_overflow),  64'(m_ovf));
    check({tag, "_le_part"},  64'(le_partial),   64'(m_cur.size()));
    check({tag, "_le_valid"}, 64'(le_out_valid), 64'(m_qle.size() > 0));
  endtask

  // Apply inputs, advance one edge in the model and the DUT, compare.
  task automatic cycle(input string tag, input bit v, input logic [7:0] d,
                       input bit f, input bit c, input bit r);
    valid     = v;
    data      = d;
    flush     = f;
    clear_ovf = c;
    out_ready = r;
    model_step(v, d, f, c, r);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, input bit r);
    for (int i = 0; i < WB; i++) begin
      cycle(tag, 1'b1, w[31-8*i -: 8], 1'b0, 1'b0, r);
    end
  endtask

  int sent;
  int budget;

  initial begin
    valid     = 1'b0;
    data      = 8'h00;
    flush     = 1'b0;
    clear_ovf = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic assembly, both byte orders, one-cycle head visibility.
    cycle("b11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    cycle("b22", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    cycle("b33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    cycle("b44", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    check("basic_be_word", 64'(be_out_data), 64'h11223344);
    check("basic_le_word", 64'(le_out_data), 64'h44332211);
    check("basic_valid_hi", 64'(be_out_valid), 64'd1);
    cycle("basic_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("basic_valid_lo", 64'(be_out_valid), 64'd0);

    // Five words into a four-deep FIFO with no consumer.
    send_word("ovf_w1", 32'hA1A2A3A4, 1'b0);
    send_word("ovf_w2", 32'hB1B2B3B4, 1'b0);
    send_word("ovf_w3", 32'hC1C2C3C4, 1'b0);
    send_word("ovf_w4", 32'hD1D2D3D4, 1'b0);
    check("ovf_pre_flag", 64'(be_overflow), 64'd0);
    send_word("ovf_w5", 32'hE1E2E3E4, 1'b0);
    check("ovf_count", 64'(be_count), 64'd4);
    check("ovf_flag", 64'(be_overflow), 64'd1);
    check("ovf_head1", 64'(be_out_data), 64'hA1A2A3A4);
    cycle("ovf_pop1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_head2", 64'(be_out_data), 64'hB1B2B3B4);
    cycle("ovf_pop2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_head3", 64'(be_out_data), 64'hC1C2C3C4);
    cycle("ovf_pop3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_head4", 64'(be_out_data), 64'hD1D2D3D4);
    cycle("ovf_pop4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_empty", 64'(be_out_valid), 64'd0);
    cycle("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_cleared", 64'(be_overflow), 64'd0);

    // Full FIFO, last byte of a word together with a pop: word kept.
    send_word("pp_w1", 32'h01010101, 1'b0);
    send_word("pp_w2", 32'h02020202, 1'b0);
    send_word("pp_w3", 32'h03030303, 1'b0);
    send_word("pp_w4", 32'h04040404, 1'b0);
    cycle("pp_b0", 1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
    cycle("pp_b1", 1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    cycle("pp_b2", 1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    cycle("pp_b3", 1'b1, 8'h53, 1'b0, 1'b0, 1'b1);
    check("pp_count", 64'(be_count), 64'd4);
    check("pp_ovf", 64'(be_overflow), 64'd0);
    check("pp_head", 64'(be_out_data), 64'h02020202);
    for (int i = 0; i < 3; i++) cycle("pp_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("pp_last", 64'(be_out_data), 64'h50515253);
    cycle("pp_drain_last", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Flush abandons a partial word.
    cycle("fl_aa", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cycle("fl_bb", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    cycle("fl_flush", 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("fl_partial0", 64'(be_partial), 64'd0);
    send_word("fl_word", 32'h01020304, 1'b0);
    check("fl_count", 64'(be_count), 64'd1);
    check("fl_data", 64'(be_out_data), 64'h01020304);
    check("fl_partial", 64'(be_partial), 64'd0);
    cycle("fl_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-word with two words queued.
    send_word("rs_w1", 32'h11111111, 1'b0);
    send_word("rs_w2", 32'h22222222, 1'b0);
    cycle("rs_b0", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cycle("rs_b1", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rs_async");
    check("rs_count0", 64'(be_count), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_word("rs_after", 32'h9ABCDEF0, 1'b0);
    check("rs_word", 64'(be_out_data), 64'h9ABCDEF0);
    check("rs_word_le", 64'(le_out_data), 64'hF0DEBC9A);
    for (int i = 0; i < 2; i++) cycle("rs_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random traffic: irregular byte gaps, random consumer, rare flush/clear.
    sent   = 0;
    budget = 0;
    while (sent < 1000 && budget < 20000) begin
      bit v;
      bit f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 59) == 0);
      if (v && !f) sent++;
      cycle("rnd", v, 8'($urandom), f, ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1));
      budget++;
    end
    check("rnd_bytes_sent", 64'(sent), 64'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
